// File: rtl/time_of_day_counter.sv
// BCD hh:mm:ss time-of-day counter advanced by rising edges of a divided square wave
// sampled in the clk domain, with clear and per-field set mode.
module time_of_day_counter #(
    parameter int HOUR_MAX    = 23,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       run,
    input  logic       set_en,
    input  logic [1:0] set_field,
    input  logic       inc_pulse,
    input  logic       clear,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic       sec_tick,
    output logic       rollover
);

    localparam logic [3:0] HMAX_TENS = 4'(HOUR_MAX / 10);
    localparam logic [3:0] HMAX_ONES = 4'(HOUR_MAX % 10);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   rise_reg;

    // Field 0 = seconds, 1 = minutes, 2 = hours; each is {tens, ones}.
    logic [2:0][7:0] field_reg;
    logic [2:0][7:0] field_next;
    logic [2:0][7:0] field_inc;
    logic [2:0]      field_wrap;
    logic            sec_tick_reg;
    logic            sec_tick_next;
    logic            rollover_reg;
    logic            rollover_next;

    // Rise is registered so the count lands SYNC_STAGES+2 cycles after the input edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
            rise_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], tick_in};
            prev_reg <= sync_reg[SYNC_STAGES-1];
            rise_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_field
            localparam logic [3:0] TENS_MAX = (gi == 2) ? HMAX_TENS : 4'd5;
            localparam logic [3:0] ONES_MAX = (gi == 2) ? HMAX_ONES : 4'd9;

            assign field_wrap[gi] = (field_reg[gi] == {TENS_MAX, ONES_MAX});

            always_comb begin
                field_inc[gi] = field_reg[gi];
                if (field_wrap[gi]) begin
                    field_inc[gi] = 8'h00;
                end else if (field_reg[gi][3:0] == 4'd9) begin
                    field_inc[gi] = {field_reg[gi][7:4] + 4'd1, 4'd0};
                end else begin
                    field_inc[gi] = {field_reg[gi][7:4], field_reg[gi][3:0] + 4'd1};
                end
            end
        end
    endgenerate

    always_comb begin
        field_next    = field_reg;
        sec_tick_next = 1'b0;
        rollover_next = 1'b0;
        if (clear) begin
            field_next = '0;
        end else if (set_en) begin
            if (inc_pulse) begin
                case (set_field)
                    2'b00:   field_next[0] = field_inc[0];
                    2'b01:   field_next[1] = field_inc[1];
                    2'b10:   field_next[2] = field_inc[2];
                    default: field_next    = field_reg;
                endcase
            end
        end else if (run && rise_reg) begin
            sec_tick_next = 1'b1;
            field_next[0] = field_inc[0];
            if (field_wrap[0]) begin
                field_next[1] = field_inc[1];
                if (field_wrap[1]) begin
                    field_next[2] = field_inc[2];
                    rollover_next = field_wrap[2];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_reg    <= '0;
            sec_tick_reg <= 1'b0;
            rollover_reg <= 1'b0;
        end else begin
            field_reg    <= field_next;
            sec_tick_reg <= sec_tick_next;
            rollover_reg <= rollover_next;
        end
    end

    assign sec_bcd  = field_reg[0];
    assign min_bcd  = field_reg[1];
    assign hour_bcd = field_reg[2];
    assign sec_tick = sec_tick_reg;
    assign rollover = rollover_reg;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter: a 24 h instance plus a 12 h (HOUR_MAX = 11) instance.
module tb_time_of_day_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_in;
    logic       run;
    logic       clear;
    logic       set_en, set_en2;
    logic [1:0] set_field, set_field2;
    logic       inc_pulse, inc_pulse2;
    logic [7:0] sec_bcd, min_bcd, hour_bcd;
    logic [7:0] sec_bcd2, min_bcd2, hour_bcd2;
    logic       sec_tick, rollover, sec_tick2, rollover2;

    int n_checks = 0;
    int n_errors = 0;

    logic tk_st, tk_ro, tk_ro2, tk_st_after, tk_ro_after;
    logic [7:0] tk_pre_sec;
    logic seen_tick;

    always #5 clk = ~clk;

    time_of_day_counter #(.HOUR_MAX(23), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .run(run),
        .set_en(set_en), .set_field(set_field), .inc_pulse(inc_pulse), .clear(clear),
        .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd),
        .sec_tick(sec_tick), .rollover(rollover)
    );

    time_of_day_counter #(.HOUR_MAX(11), .SYNC_STAGES(2)) dut12 (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .run(run),
        .set_en(set_en2), .set_field(set_field2), .inc_pulse(inc_pulse2), .clear(clear),
        .sec_bcd(sec_bcd2), .min_bcd(min_bcd2), .hour_bcd(hour_bcd2),
        .sec_tick(sec_tick2), .rollover(rollover2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_inc(input int which, input logic [1:0] field);
        if (which == 0) begin
            set_field = field; inc_pulse = 1'b1; step(); inc_pulse = 1'b0;
        end else begin
            set_field2 = field; inc_pulse2 = 1'b1; step(); inc_pulse2 = 1'b0;
        end
    endtask

    // Clears both instances, then steps the selected one to h:m:s through set mode.
    task automatic preset(input int which, input int h, input int m, input int s);
        clear = 1'b1; step(); clear = 1'b0;
        if (which == 0) set_en = 1'b1; else set_en2 = 1'b1;
        for (int i = 0; i < h; i++) pulse_inc(which, 2'b10);
        for (int i = 0; i < m; i++) pulse_inc(which, 2'b01);
        for (int i = 0; i < s; i++) pulse_inc(which, 2'b00);
        set_en = 1'b0; set_en2 = 1'b0;
        step();
        $display("preset dut%0d to %0d:%0d:%0d", which, h, m, s);
    endtask

    // One 0->1->0 tick_in pulse; count update expected on the 4th edge after the rise.
    task automatic do_tick();
        tick_in = 1'b1;
        step(); step(); step();
        tk_pre_sec = sec_bcd;
        step();
        tk_st = sec_tick; tk_ro = rollover; tk_ro2 = rollover2;
        step();
        tk_st_after = sec_tick; tk_ro_after = rollover;
        tick_in = 1'b0;
        step(); step(); step();
        $display("tick: dut %h:%h:%h  dut12 %h:%h:%h", hour_bcd, min_bcd, sec_bcd,
                 hour_bcd2, min_bcd2, sec_bcd2);
    endtask

    initial begin
        rst_n = 1'b0; tick_in = 1'b0; run = 1'b1; clear = 1'b0;
        set_en = 1'b0; set_field = 2'b00; inc_pulse = 1'b0;
        set_en2 = 1'b0; set_field2 = 2'b00; inc_pulse2 = 1'b0;
        step(); step();
        check_eq("reset_sec", sec_bcd, 8'h00);
        check_eq("reset_min", min_bcd, 8'h00);
        check_eq("reset_hour", hour_bcd, 8'h00);
        check_eq("reset_sec_tick", sec_tick, 1'b0);
        check_eq("reset_rollover", rollover, 1'b0);
        rst_n = 1'b1;
        step(); step();

        // First tick and its latency
        do_tick();
        check_eq("t1_sec_before", tk_pre_sec, 8'h00);
        check_eq("t1_sec_tick", tk_st, 1'b1);
        check_eq("t1_sec_tick_after", tk_st_after, 1'b0);
        check_eq("t1_sec", sec_bcd, 8'h01);

        // Seconds carry into minutes
        preset(0, 0, 0, 59);
        do_tick();
        check_eq("t2_sec", sec_bcd, 8'h00);
        check_eq("t2_min", min_bcd, 8'h01);
        check_eq("t2_hour", hour_bcd, 8'h00);
        check_eq("t2_rollover", tk_ro, 1'b0);

        // Full-day rollover
        preset(0, 23, 59, 59);
        check_eq("t3_hour_preset", hour_bcd, 8'h23);
        do_tick();
        check_eq("t3_sec", sec_bcd, 8'h00);
        check_eq("t3_min", min_bcd, 8'h00);
        check_eq("t3_hour", hour_bcd, 8'h00);
        check_eq("t3_rollover", tk_ro, 1'b1);
        check_eq("t3_rollover_after", tk_ro_after, 1'b0);

        // Set mode: minute wraps without carry, ticks ignored, field 11 ignored
        preset(0, 5, 59, 30);
        set_en = 1'b1;
        pulse_inc(0, 2'b01);
        check_eq("t4_min_wrap", min_bcd, 8'h00);
        check_eq("t4_hour_kept", hour_bcd, 8'h05);
        seen_tick = 1'b0;
        tick_in = 1'b1;
        for (int i = 0; i < 6; i++) begin step(); seen_tick |= sec_tick; end
        tick_in = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); seen_tick |= sec_tick; end
        check_eq("t4_sec_held", sec_bcd, 8'h30);
        check_eq("t4_no_sec_tick", seen_tick, 1'b0);
        pulse_inc(0, 2'b11);
        step();
        check_eq("t4_none_sec", sec_bcd, 8'h30);
        check_eq("t4_none_min", min_bcd, 8'h00);
        check_eq("t4_none_hour", hour_bcd, 8'h05);
        set_en = 1'b0;
        step(); step();
        check_eq("t4_no_catchup", sec_bcd, 8'h30);
        do_tick();
        check_eq("t4_resume", sec_bcd, 8'h31);

        preset(0, 23, 0, 0);
        set_en = 1'b1;
        pulse_inc(0, 2'b10);
        set_en = 1'b0;
        check_eq("t4_hour_wrap", hour_bcd, 8'h00);

        // Clear in the same cycle as the registered rise
        preset(0, 12, 34, 56);
        check_eq("t5_preset", {hour_bcd, min_bcd, sec_bcd}, 24'h123456);
        tick_in = 1'b1;
        step(); step(); step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_eq("t5_cleared", {hour_bcd, min_bcd, sec_bcd}, 24'h000000);
        check_eq("t5_sec_tick", sec_tick, 1'b0);
        tick_in = 1'b0;
        step(); step(); step();
        check_eq("t5_still_zero", sec_bcd, 8'h00);

        // Hold with run = 0, ticks not queued
        preset(0, 0, 0, 7);
        run = 1'b0;
        for (int i = 0; i < 5; i++) do_tick();
        check_eq("t5_hold", sec_bcd, 8'h07);
        run = 1'b1;
        step(); step(); step(); step();
        check_eq("t5_no_queue", sec_bcd, 8'h07);

        // tick_in held high for 100 cycles
        preset(0, 0, 0, 0);
        tick_in = 1'b1;
        for (int i = 0; i < 100; i++) step();
        tick_in = 1'b0;
        step(); step(); step();
        check_eq("t6_held_once", sec_bcd, 8'h01);

        // Asynchronous reset mid-count, released with tick_in already high
        preset(0, 3, 4, 5);
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_rst", {hour_bcd, min_bcd, sec_bcd}, 24'h000000);
        tick_in = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step(); step(); step();
        check_eq("t6_rel_before", sec_bcd, 8'h00);
        step();
        check_eq("t6_rel_sec", sec_bcd, 8'h01);
        check_eq("t6_rel_sec_tick", sec_tick, 1'b1);
        tick_in = 1'b0;
        step(); step(); step(); step();

        // 12 h instance rollover
        preset(1, 11, 59, 59);
        check_eq("t3b_hour_preset", hour_bcd2, 8'h11);
        do_tick();
        check_eq("t3b_time", {hour_bcd2, min_bcd2, sec_bcd2}, 24'h000000);
        check_eq("t3b_rollover", tk_ro2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
